// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared CPU bus types and RAM geometry
// Contents:
//   RAM_ADDR_W, RAM_DATA_W : geometry of the 128x8 CPU data RAM
//   arb_state_t            : RAM access arbiter states
package cpu_bus_pkg;

    localparam int RAM_ADDR_W = 7;
    localparam int RAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// rtl/ram_arb_starve_cnt.sv - starvation counter for the RAM access arbiter
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : return the count to zero (has priority over inc)
//   inc        : advance the count by one
//   tc         : count has reached MAX_WAIT-1
module ram_arb_starve_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The arbiter never increments once tc is seen, so the count stops at
    // MAX_WAIT-1 and cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - CPU/debug arbiter for the single-port 128x8 data RAM
// Ports:
//   clk, reset                               : clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata        : CPU access, CPU has priority
//   cpu_rdata, cpu_stall                     : CPU read data, forced-slot stall
//   dbg_req/dbg_we/dbg_addr/dbg_wdata        : debug access, held until dbg_gnt
//   dbg_gnt, dbg_rvalid, dbg_rdata           : grant and registered read return
//   ram_addr/ram_data/ram_en, ram_q          : RAM side (ram_q combinational)
module ram_access_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W   = RAM_ADDR_W,
    parameter int DATA_W   = RAM_DATA_W,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_q
);

    arb_state_t        state_q, state_d;
    logic              cnt_clr, cnt_inc, cnt_tc;
    logic              blocked;
    logic              in_force;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    ram_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    assign blocked  = dbg_req & cpu_req;
    assign in_force = (state_q == ARB_FORCE);

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            ARB_IDLE, ARB_WAIT: begin
                if (blocked) begin
                    // Terminal count: this was the last tolerated blocked
                    // cycle, the next one is taken from the CPU.
                    if (cnt_tc) begin
                        state_d = ARB_FORCE;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = ARB_WAIT;
                    end
                end else begin
                    // Either granted in an idle CPU cycle or the requester
                    // withdrew; both end the starvation episode.
                    cnt_clr = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            ARB_FORCE: begin
                // The forced slot is spent even if dbg_req dropped.
                cnt_clr = 1'b1;
                state_d = ARB_IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are masked during reset so nothing reaches the RAM.
    assign dbg_gnt   = ~reset & dbg_req & (in_force | ~cpu_req);
    assign cpu_stall = ~reset & cpu_req & in_force;

    always_comb begin
        if (dbg_gnt) begin
            ram_addr = dbg_addr;
            ram_data = dbg_wdata;
            ram_en   = dbg_we;
        end else begin
            ram_addr = cpu_addr;
            ram_data = cpu_wdata;
            ram_en   = ~reset & cpu_we & cpu_req;
        end
    end

    assign cpu_rdata = ram_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= dbg_gnt & ~dbg_we;
            if (dbg_gnt & ~dbg_we) begin
                rdata_q <= ram_q;
            end
        end
    end

    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;

endmodule
